// File: rtl/rom_burst_reader_pkg.sv
// Shared types and constants for the ROM burst reader.
package rom_burst_reader_pkg;

    // Burst sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Output FIFO depth: two in-flight-free slots plus the ROM read pipeline
    // stage is enough to sustain one word per cycle.
    localparam int FIFO_DEPTH = 3;

    // Response entry for the standard 64-bit ROM configuration.
    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        err;
    } resp_entry_d64_t;

    // Advance a FIFO pointer, wrapping at the (non power-of-two) depth.
    function automatic logic [1:0] ptr_next(input logic [1:0] ptr);
        return (ptr == 2'(FIFO_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/rom_burst_reader_fifo.sv
// Three-entry synchronous FIFO with occupancy count, reset and flush.
// The head entry is presented combinationally and only moves on pop.
module rom_burst_reader_fifo
    import rom_burst_reader_pkg::*;
#(
    parameter int width = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [width-1:0] wdata,
    input  logic             pop,
    output logic [width-1:0] rdata,
    output logic [1:0]       count,
    output logic             empty
);

    logic [width-1:0] mem [FIFO_DEPTH];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and count; reset also clears storage so the head reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 2'd1;
            end else if (!do_push && do_pop) begin
                count <= count - 2'd1;
            end
        end
    end

    // The issue rule upstream must never let a push land on a full FIFO.
    always @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst read front end for the ROM wrapper: takes {byte address, length},
// walks the ROM word addresses, captures the 1-cycle-latency read data and
// streams it out through a small FIFO with backpressure.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. A source keeps valid and its payload stable until that cycle; ready
// may change freely and never depends combinationally on the same channel's
// valid.
module rom_burst_reader
    import rom_burst_reader_pkg::*;
#(
    parameter int abits       = 6,
    parameter int log2_dbytes = 3,
    parameter int lenbits     = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic [abits-1:0]               i_req_addr,
    input  logic [lenbits-1:0]             i_req_len,
    output logic                           o_resp_valid,
    input  logic                           i_resp_ready,
    output logic [8*(2**log2_dbytes)-1:0]  o_resp_data,
    output logic                           o_resp_last,
    output logic                           o_resp_err,
    output logic [abits-log2_dbytes-1:0]   o_rom_addr,
    input  logic [8*(2**log2_dbytes)-1:0]  i_rom_rdata,
    output logic [1:0]                     o_dbg_state
);

    localparam int dbits = 8 * (2 ** log2_dbytes);
    localparam int wbits = abits - log2_dbytes;

    typedef struct packed {
        logic [dbits-1:0] data;
        logic             last;
        logic             err;
    } resp_entry_t;

    state_t             state;
    state_t             state_next;
    logic [lenbits-1:0] remaining;
    logic               burst_err;
    logic               inflight;
    logic               inflight_last;
    logic               req_fire;
    logic               issue;
    logic               beat_fire;
    logic [1:0]         fifo_count;
    logic               fifo_empty;
    logic [2:0]         occupancy;
    resp_entry_t        push_entry;
    resp_entry_t        head_entry;

    assign req_fire  = i_req_valid && o_req_ready;
    assign beat_fire = o_resp_valid && i_resp_ready;
    // Words held or on their way: issuing only below depth means the word
    // returning next cycle always has a free slot.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    assign issue     = (state == READ) && (occupancy < 3'(FIFO_DEPTH));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and request-ready decode.
    always_comb begin
        state_next  = state;
        o_req_ready = 1'b0;
        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (issue && (remaining == '0)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (beat_fire && o_resp_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address walk, remaining count, error flag and ROM pipeline tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rom_addr    <= '0;
            remaining     <= '0;
            burst_err     <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= issue;
            if (req_fire) begin
                o_rom_addr <= i_req_addr[abits-1:log2_dbytes];
                remaining  <= i_req_len;
                burst_err  <= |i_req_addr[log2_dbytes-1:0];
            end else if (issue) begin
                o_rom_addr <= o_rom_addr + wbits'(1);
                remaining  <= remaining - lenbits'(1);
            end
            if (issue) begin
                inflight_last <= (remaining == '0);
            end
        end
    end

    assign push_entry.data = i_rom_rdata;
    assign push_entry.last = inflight_last;
    assign push_entry.err  = burst_err;

    rom_burst_reader_fifo #(
        .width ($bits(resp_entry_t))
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .flush (1'b0),
        .push  (inflight),
        .wdata (push_entry),
        .pop   (beat_fire),
        .rdata (head_entry),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign o_resp_valid = !fifo_empty;
    assign o_resp_data  = head_entry.data;
    assign o_resp_last  = head_entry.last;
    assign o_resp_err   = head_entry.err;
    assign o_dbg_state  = state;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: ROM model, request driver, expected-beat queue
// built from the address/length rules, per-cycle protocol checks.
module tb_rom_burst_reader;
    import rom_burst_reader_pkg::*;

    localparam int abits       = 6;
    localparam int log2_dbytes = 3;
    localparam int lenbits     = 8;
    localparam int dbits       = 64;
    localparam int wbits       = 3;
    localparam int nwords      = 8;
    localparam int ew          = dbits + 2;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_req_valid = 1'b0;
    logic               o_req_ready;
    logic [abits-1:0]   i_req_addr = '0;
    logic [lenbits-1:0] i_req_len = '0;
    logic               o_resp_valid;
    logic               i_resp_ready = 1'b0;
    logic [dbits-1:0]   o_resp_data;
    logic               o_resp_last;
    logic               o_resp_err;
    logic [wbits-1:0]   o_rom_addr;
    logic [dbits-1:0]   i_rom_rdata;
    logic [1:0]         o_dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [ew-1:0] exp_q[$];
    int beat_cyc[$];
    int first_valid_cyc = -1;
    bit busy = 1'b0;
    bit prev_stall = 1'b0;
    logic [dbits-1:0] prev_data;
    logic prev_last;
    logic prev_err;

    rom_burst_reader #(
        .abits       (abits),
        .log2_dbytes (log2_dbytes),
        .lenbits     (lenbits)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_len    (i_req_len),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_resp_data  (o_resp_data),
        .o_resp_last  (o_resp_last),
        .o_resp_err   (o_resp_err),
        .o_rom_addr   (o_rom_addr),
        .i_rom_rdata  (i_rom_rdata),
        .o_dbg_state  (o_dbg_state)
    );

    // Clock.
    always #5 i_clk = ~i_clk;

    function automatic logic [dbits-1:0] rom_word(input int idx);
        return 64'hA5A5_0000_0000_0000 + 64'(idx);
    endfunction

    // ROM macro model: registered read, one cycle of latency.
    always @(posedge i_clk) begin
        i_rom_rdata <= rom_word(int'(o_rom_addr));
    end

    task automatic check(input string tag, input logic [ew-1:0] got, input logic [ew-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Per-cycle scoreboard and protocol checks on the current outputs/inputs.
    task automatic observe();
        logic [ew-1:0] e;
        if (i_rst) begin
            prev_stall = 1'b0;
            return;
        end
        check("occupancy_le_3", ew'((dut.fifo_count + dut.inflight) <= 3), ew'(1));
        check("req_ready", o_req_ready, !busy);
        if (prev_stall) begin
            check("stall_valid", o_resp_valid, 1'b1);
            check("stall_data", o_resp_data, prev_data);
            check("stall_last", o_resp_last, prev_last);
            check("stall_err", o_resp_err, prev_err);
        end
        if (o_resp_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (o_resp_valid && i_resp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", o_resp_data, e[ew-1:2]);
                check("beat_last", o_resp_last, e[1]);
                check("beat_err", o_resp_err, e[0]);
                beat_cyc.push_back(cyc);
                if (e[1]) busy = 1'b0;
            end
        end
        prev_stall = o_resp_valid && !i_resp_ready;
        prev_data  = o_resp_data;
        prev_last  = o_resp_last;
        prev_err   = o_resp_err;
    endtask

    task automatic step();
        observe();
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic drive_ready(input int mode);
        i_resp_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    // Issue one request and queue the beats it must produce.
    task automatic start_burst(input logic [abits-1:0] addr, input int len, input int mode, output int c0);
        int word;
        word = int'(addr) / 8;
        for (int k = 0; k <= len; k++) begin
            exp_q.push_back({rom_word((word + k) % nwords), (k == len), ((int'(addr) % 8) != 0)});
        end
        beat_cyc.delete();
        first_valid_cyc = -1;
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        i_req_len   = lenbits'(len);
        drive_ready(mode);
        c0 = cyc;
        step();
        busy = 1'b1;
        i_req_valid = 1'b0;
    endtask

    // Full burst: wait for ready, request, collect all beats, check timing.
    task automatic run_burst(input logic [abits-1:0] addr, input int len, input int mode, input string name);
        int c0;
        int n;
        n = 0;
        i_req_valid = 1'b0;
        while (!o_req_ready && n < 50) begin
            drive_ready(mode);
            step();
            n++;
        end
        check({name, "_req_ready_wait"}, o_req_ready, 1'b1);
        start_burst(addr, len, mode, c0);
        n = 0;
        while (busy && n < 400) begin
            // Requests offered mid-burst must be ignored.
            i_req_valid = 1'($urandom_range(0, 1));
            i_req_addr  = abits'($urandom);
            i_req_len   = lenbits'($urandom);
            drive_ready(mode);
            step();
            n++;
        end
        i_req_valid = 1'b0;
        check({name, "_completed"}, busy, 1'b0);
        check({name, "_beat_count"}, beat_cyc.size(), len + 1);
        check({name, "_first_valid_lat"}, first_valid_cyc - c0, 3);
        if (mode == 0) begin
            for (int k = 0; k < beat_cyc.size(); k++) begin
                check({name, "_beat_timing"}, beat_cyc[k] - c0, 3 + k);
            end
        end
        check({name, "_req_ready_after"}, o_req_ready, 1'b1);
    endtask

    initial begin
        int c0;
        int n;
        // Power-on reset.
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        check("rst_resp_valid", o_resp_valid, 1'b0);
        check("rst_resp_data", o_resp_data, '0);
        check("rst_resp_last", o_resp_last, 1'b0);
        check("rst_resp_err", o_resp_err, 1'b0);
        check("rst_rom_addr", o_rom_addr, '0);
        check("rst_req_ready", o_req_ready, 1'b1);
        check("rst_state", o_dbg_state, IDLE);

        // Directed cases.
        run_burst(6'h10, 0, 0, "single");
        run_burst(6'h00, 3, 0, "burst4");
        run_burst(6'h30, 3, 0, "wrap");
        run_burst(6'h00, 7, 1, "backpressure");
        run_burst(6'h13, 1, 0, "misaligned");

        // Reset after the third beat of an 8-word burst.
        start_burst(6'h00, 7, 0, c0);
        n = 0;
        while (beat_cyc.size() < 3 && n < 50) begin
            i_resp_ready = 1'b1;
            step();
            n++;
        end
        check("rstmid_beats_before", beat_cyc.size(), 3);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        exp_q.delete();
        busy = 1'b0;
        prev_stall = 1'b0;
        check("rstmid_resp_valid", o_resp_valid, 1'b0);
        check("rstmid_req_ready", o_req_ready, 1'b1);
        check("rstmid_state", o_dbg_state, IDLE);
        run_burst(6'h08, 0, 0, "post_reset");

        // Randomised bursts with random backpressure.
        for (int t = 0; t < 12; t++) begin
            run_burst(abits'($urandom_range(0, 63)), $urandom_range(0, 10), $urandom_range(0, 1), "random");
        end

        // Idle tail: nothing may appear.
        for (int t = 0; t < 5; t++) begin
            i_resp_ready = 1'b1;
            step();
        end
        check("tail_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
